zl_rs_encoder_ilv: RTL



---
 rtl/zl_rs_encoder_ilv.sv | 98 +++++++++
 1 files changed

// File: rtl/zl_rs_encoder_ilv.sv
// Symbol-interleaved RS(N,K) encoder: I channel LFSRs share one GF multiplier bank.
// Optional ZL_RS_ENC_FRAME_FLAGS_EN adds data_out_sof/data_out_eof frame markers.
module zl_rs_encoder_ilv #(
    parameter int unsigned N = 204,
    parameter int unsigned K = 188,
    parameter int unsigned M = 8,
    parameter int unsigned I = 2,
    parameter logic [(N-K)*M-1:0] G_x = '0,
    parameter logic [M:0] Gf_poly = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         data_in_req,
    output logic         data_in_ack,
    input  logic [M-1:0] data_in,
    output logic         data_out_req,
    input  logic         data_out_ack,
    output logic [M-1:0] data_out
`ifdef ZL_RS_ENC_FRAME_FLAGS_EN
    ,
    output logic         data_out_sof,
    output logic         data_out_eof
`endif
);

    localparam int unsigned P  = N - K;
    localparam int unsigned CW = (I > 1) ? $clog2(I) : 1;
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] ch_q;
    logic [SW-1:0] sym_q;
    logic [M-1:0]  lfsr_q  [I][P];
    logic [M-1:0]  sel_row [P];
    logic [M-1:0]  lfsr_d  [P];
    logic [M-1:0]  fb;
    logic          is_data;
    logic          xfer;

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] aa;
        acc = '0;
        aa  = a;
        for (int i = 0; i < int'(M); i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = aa[M-1] ? ((aa << 1) ^ Gf_poly[M-1:0]) : (aa << 1);
        end
        return acc;
    endfunction

    assign is_data      = (sym_q < SW'(K));
    assign data_out_req = is_data ? data_in_req : 1'b1;
    assign data_in_ack  = data_out_ack & is_data & data_in_req;
    assign xfer         = data_out_req & data_out_ack;
    assign data_out     = is_data ? data_in : sel_row[P-1];

    // Single multiplier bank: only the active channel's row is routed through it.
    always_comb begin
        sel_row = '{default: '0};
        for (int c = 0; c < int'(I); c++) begin
            if (ch_q == CW'(c)) sel_row = lfsr_q[c];
        end
        fb = is_data ? (sel_row[P-1] ^ data_in) : '0;
        lfsr_d[0] = gf_mul(fb, G_x[0 +: M]);
        for (int j = 1; j < int'(P); j++) begin
            lfsr_d[j] = sel_row[j-1] ^ gf_mul(fb, G_x[j*M +: M]);
        end
    end

    // Parity phase feeds back zero, so every LFSR is empty again when the block wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_q  <= '0;
            sym_q <= '0;
            for (int c = 0; c < int'(I); c++) begin
                for (int j = 0; j < int'(P); j++) begin
                    lfsr_q[c][j] <= '0;
                end
            end
        end else if (xfer) begin
            for (int c = 0; c < int'(I); c++) begin
                if (ch_q == CW'(c)) lfsr_q[c] <= lfsr_d;
            end
            if (ch_q == CW'(I - 1)) begin
                ch_q  <= '0;
                sym_q <= (sym_q == SW'(N - 1)) ? '0 : sym_q + 1'b1;
            end else begin
                ch_q <= ch_q + 1'b1;
            end
        end
    end

`ifdef ZL_RS_ENC_FRAME_FLAGS_EN
    assign data_out_sof = data_out_req & (sym_q == '0) & (ch_q == '0);
    assign data_out_eof = data_out_req & (sym_q == SW'(N - 1)) & (ch_q == CW'(I - 1));
`endif

endmodule
